core_sequencer: RTL

//   Multi-cycle control FSM for the single-issue core. Drives the 3-bit stage code consumed
//   by fetch/decode/execute/mem/write (execute latches its flags only while state==EXEC).

---
 rtl/core_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue core: FETCH/DECODE/EXEC/MEM/WRITE/HALT.
// Ports: clk, rst (sync, active-high), halt_req, fetch_ack, exec_multi, exec_busy,
//   mem_access, mem_ack in; state, fetch_req, mem_req, reg_we_stb, pc_update,
//   halted, timeout_err, retired_cnt out.
module core_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             fetch_ack,
    input  logic             exec_multi,
    input  logic             exec_busy,
    input  logic             mem_access,
    input  logic             mem_ack,
    output logic [2:0]       state,
    output logic             fetch_req,
    output logic             mem_req,
    output logic             reg_we_stb,
    output logic             pc_update,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_cnt
);

    // Wide enough to hold TIMEOUT-1, the last stall count before expiry.
    localparam int unsigned WC_W =
        (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [WC_W-1:0] WC_LAST =
        (TIMEOUT == 0) ? '0 : WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              multi_q, multi_d;
    logic              hpend_q, hpend_d;
    logic              tmo_q, tmo_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            multi_q <= 1'b0;
            hpend_q <= 1'b0;
            tmo_q   <= 1'b0;
            wait_q  <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            multi_q <= multi_d;
            hpend_q <= hpend_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        multi_d = multi_q;
        hpend_d = hpend_q | halt_req;
        tmo_d   = tmo_q;
        ret_d   = ret_q;
        stall   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (fetch_ack) state_d = S_DECODE;
                else           stall   = 1'b1;
            end
            S_DECODE: begin
                multi_d = exec_multi;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // busy only matters for instructions on the multi-cycle unit
                if (multi_q && exec_busy) stall   = 1'b1;
                else                      state_d = S_MEM;
            end
            S_MEM: begin
                if (mem_access && !mem_ack) stall   = 1'b1;
                else                        state_d = S_WRITE;
            end
            S_WRITE: begin
                ret_d   = ret_q + CNT_W'(1);
                state_d = (hpend_q || halt_req) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A stall cycle that would be the TIMEOUT-th one aborts to HALT;
        // an ack/!busy in that same cycle is not a stall and wins.
        if (WD_EN && stall && (wait_q == WC_LAST)) begin
            state_d = S_HALT;
            tmo_d   = 1'b1;
        end

        if (state_d != state_q) wait_d = '0;
        else if (stall)         wait_d = wait_q + WC_W'(1);
        else                    wait_d = wait_q;
    end

    assign state       = state_q;
    assign fetch_req   = (state_q == S_FETCH) && !rst;
    assign mem_req     = (state_q == S_MEM) && mem_access && !rst;
    assign reg_we_stb  = (state_q == S_WRITE) && !rst;
    assign pc_update   = (state_q == S_WRITE) && !rst;
    assign halted      = (state_q == S_HALT);
    assign timeout_err = tmo_q;
    assign retired_cnt = ret_q;

endmodule
